// File: rtl/clock_ui_pkg.sv
// Shared definitions for the clock user-interface front end:
// per-channel FSM encoding, default timing constants and a popcount helper.
package clock_ui_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int unsigned DEF_N_BTN         = 2;
    localparam int unsigned DEF_DEBOUNCE_CYC  = 1_250_000;
    localparam int unsigned DEF_REPEAT_DELAY  = 62_500_000;
    localparam int unsigned DEF_REPEAT_PERIOD = 25_000_000;
    localparam int unsigned DEF_CNT_W         = 27;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            n += {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce counter and
// press / auto-repeat FSM producing a one-cycle pulse per event.
module btn_channel
    import clock_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_rp_cnt;
    logic             r_level;
    logic             r_pulse;
    btn_state_t       r_state;

    logic w_s;
    logic w_accept;
    logic w_rise;
    logic w_fall;

    // Level-change events are decoded combinationally so the FSM reacts on
    // the same edge that updates r_level.
    always_comb begin
        w_s      = r_sync[1];
        w_accept = (w_s != r_level) && (r_db_cnt == DB_LAST);
        w_rise   = w_accept && w_s;
        w_fall   = w_accept && !w_s;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= '0;
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (w_s == r_level) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_level  <= w_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + ONE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_rp_cnt <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_rp_cnt <= '0;
                    if (w_rise) begin
                        r_pulse <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_fall) begin
                        r_rp_cnt <= '0;
                        r_state  <= IDLE;
                    end else if (r_rp_cnt == RD_LAST) begin
                        r_pulse  <= 1'b1;
                        r_rp_cnt <= '0;
                        r_state  <= REPEAT;
                    end else begin
                        r_rp_cnt <= r_rp_cnt + ONE;
                    end
                end
                REPEAT: begin
                    if (w_fall) begin
                        r_rp_cnt <= '0;
                        r_state  <= IDLE;
                    end else if (r_rp_cnt == RP_LAST) begin
                        r_pulse  <= 1'b1;
                        r_rp_cnt <= '0;
                    end else begin
                        r_rp_cnt <= r_rp_cnt + ONE;
                    end
                end
                default: begin
                    r_rp_cnt <= '0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_conditioner.sv
// Button front end for the time-set logic: per-channel conditioning plus
// chord detection that suppresses all pulses while more than one button is held.
module btn_conditioner
    import clock_ui_pkg::*;
#(
    parameter int unsigned N_BTN         = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             chord
);

    logic [N_BTN-1:0] w_ch_pulse;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_ch (
            .i_clk  (clk),
            .i_rst  (reset),
            .i_raw  (btn_raw[g]),
            .o_level(btn_level[g]),
            .o_pulse(w_ch_pulse[g])
        );
    end

    // Chord and mask use the same registered levels, so a second button's
    // own press pulse is already masked on the edge it is accepted.
    always_comb begin
        chord     = (popcount(32'(btn_level)) > 1);
        btn_pulse = w_ch_pulse & ~{N_BTN{chord}};
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_btn_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn_raw = 2'b00;
    logic [1:0] btn_level;
    logic [1:0] btn_pulse;
    logic       chord;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    btn_conditioner #(
        .N_BTN        (2),
        .DEBOUNCE_CYC (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .CNT_W        (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .chord    (chord)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: s is raw delayed two edges; a level flips after DB
    // consecutive disagreeing edges; pulses at press and at RD, RD+RP, ...
    // edges of continuous hold; chord masks everything.
    bit m_s1[2];
    bit m_s2[2];
    bit m_level[2];
    int m_run[2];
    int m_since[2];
    bit m_pulse[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0;
                m_run[i] = 0; m_since[i] = 0; m_pulse[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit old_lvl;
                bit s;
                old_lvl = m_level[i];
                s = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = btn_raw[i];
                m_pulse[i] = 0;
                if (s != old_lvl) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_level[i] = s;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_level[i] && !old_lvl) begin
                    m_since[i] = 0;
                    m_pulse[i] = 1;
                end else if (m_level[i]) begin
                    m_since[i]++;
                    if (m_since[i] == RD || (m_since[i] > RD && (m_since[i] - RD) % RP == 0))
                        m_pulse[i] = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en && !reset) begin
            logic       m_chord;
            logic [1:0] exp_lvl;
            logic [1:0] exp_pls;
            exp_lvl = {m_level[1], m_level[0]};
            m_chord = m_level[0] && m_level[1];
            exp_pls = m_chord ? 2'b00 : {m_pulse[1], m_pulse[0]};
            chk("model_level", 32'(btn_level), 32'(exp_lvl));
            chk("model_pulse", 32'(btn_pulse), 32'(exp_pls));
            chk("model_chord", 32'(chord), 32'(m_chord));
        end
    end

    function automatic bit on_sched(input int d);
        return d inside {0, 10, 15, 20, 25, 30, 35, 40};
    endfunction

    int tmr[2];

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_level", 32'(btn_level), 32'd0);
        chk("reset_pulse", 32'(btn_pulse), 32'd0);
        chk("reset_chord", 32'(chord), 32'd0);
        reset = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press and long hold; release lands level-fall on the +45 repeat edge.
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            chk($sformatf("press_level_k%0d", k), 32'(btn_level[0]), 32'(k >= 6));
            chk($sformatf("press_pulse_k%0d", k), 32'(btn_pulse[0]), 32'(k >= 6 && on_sched(k - 6)));
        end
        btn_raw[0] = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk($sformatf("release_level_j%0d", j), 32'(btn_level[0]), 32'(j < 6));
            chk($sformatf("release_pulse_j%0d", j), 32'(btn_pulse[0]), 32'(j == 1));
        end
        repeat (10) @(negedge clk);

        // Bounce: 1,0,1,0 then steady 1.
        btn_raw[0] = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            chk("bounce_quiet", 32'(btn_pulse[0]), 32'd0);
            btn_raw[0] = (b % 2 == 0);
        end
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk($sformatf("bounce_pulse_j%0d", j), 32'(btn_pulse[0]), 32'(j == 6));
            chk($sformatf("bounce_level_j%0d", j), 32'(btn_level[0]), 32'(j >= 6));
        end
        btn_raw[0] = 1'b0;
        repeat (16) @(negedge clk);

        // Chord: btn1 accepted at edge 6, btn0 accepted at 15, released to fall at 26.
        btn_raw[1] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            chk($sformatf("chord_lvl1_e%0d", e), 32'(btn_level[1]), 32'(e >= 6));
            if (e >= 10) begin
                chk($sformatf("chord_flag_e%0d", e), 32'(chord), 32'(e >= 15 && e < 26));
                chk($sformatf("chord_p0_e%0d", e), 32'(btn_pulse[0]), 32'd0);
                chk($sformatf("chord_p1_e%0d", e), 32'(btn_pulse[1]), 32'(e inside {26, 31, 36}));
            end
            if (e == 9)  btn_raw[0] = 1'b1;
            if (e == 20) btn_raw[0] = 1'b0;
        end
        btn_raw[1] = 1'b0;
        repeat (12) @(negedge clk);

        // Reset asserted mid-REPEAT with the button still held.
        btn_raw[0] = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midreset_level", 32'(btn_level), 32'd0);
        chk("midreset_pulse", 32'(btn_pulse), 32'd0);
        chk("midreset_chord", 32'(chord), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk($sformatf("repress_pulse_j%0d", j), 32'(btn_pulse[0]), 32'(j == 6));
            chk($sformatf("repress_level_j%0d", j), 32'(btn_level[0]), 32'(j >= 6));
        end
        btn_raw[0] = 1'b0;
        repeat (12) @(negedge clk);

        // Randomized holds and bounces with occasional asynchronous resets.
        tmr[0] = 0;
        tmr[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (tmr[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    tmr[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(5, 60));
                end else begin
                    tmr[i]--;
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                #1;
                chk("rand_reset_level", 32'(btn_level), 32'd0);
                chk("rand_reset_pulse", 32'(btn_pulse), 32'd0);
                @(negedge clk);
                reset = 1'b0;
            end
        end
        cmp_en = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
